// File: rtl/if_pkg.sv
// Shared IF-stage definitions: fetch FSM encoding and instruction/PC constants.
package if_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  // Instruction presented to ID when the slot is empty
  localparam logic [31:0] IF_NOP = 32'h0000_0000;

  // Sequential fetch stride
  localparam logic [31:0] PC_INC = 32'd4;

  // Word-align an instruction address
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/if_wait_timer.sv
// Counts cycles an instruction-memory request has been waiting for its ack.
// clr has priority over inc; the count saturates at MAX_WAIT.
module if_wait_timer #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  assign hit = (cnt == CNT_W'(MAX_WAIT));

  // Wait counter: clear on completion, step while the request is unanswered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues req/ack reads to
// instruction memory and holds one registered instruction+PC slot for ID.
// Handles stalls, redirects and a memory that never acknowledges.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        timeout_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         pending_q, pending_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  slot_pc_q, slot_pc_d;
  logic         terr_q, terr_d;

  logic         timer_hit;
  logic         timer_clr;
  logic         timer_inc;

  assign imem_addr   = addr_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = slot_pc_q;
  assign timeout_err = terr_q;

  // Request-wait supervision: any outstanding cycle counts, completion clears
  assign timer_inc = imem_req && !imem_ack;
  assign timer_clr = (imem_req && imem_ack) || (redirect_valid && !imem_req);

  if_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .hit   (timer_hit)
  );

  // Next-state, request decode and slot/PC update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    slot_pc_d = slot_pc_q;
    terr_d    = terr_q;
    imem_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) begin
          pc_d = align_pc(redirect_pc);
        end
      end

      FETCH: begin
        // A pending request must stay up; otherwise only fetch when the slot will be free
        imem_req = pending_q || !valid_q || !stall;
        if (timer_hit) begin
          state_d   = ERR;
          terr_d    = 1'b1;
          valid_d   = 1'b0;
          instr_d   = IF_NOP;
          pending_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d      = align_pc(redirect_pc);
          valid_d   = 1'b0;
          instr_d   = IF_NOP;
          pending_d = 1'b0;
          // The stale request still has to complete before the new address goes out
          if (imem_req && !imem_ack) begin
            state_d = DRAIN;
          end
        end else begin
          pending_d = imem_req && !imem_ack;
          if (imem_req && imem_ack) begin
            valid_d   = 1'b1;
            instr_d   = imem_rdata;
            slot_pc_d = pc_q;
            pc_d      = pc_q + PC_INC;
          end else if (valid_q && !stall) begin
            valid_d = 1'b0;
            instr_d = IF_NOP;
          end
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (timer_hit) begin
          state_d   = ERR;
          terr_d    = 1'b1;
          valid_d   = 1'b0;
          instr_d   = IF_NOP;
          pending_d = 1'b0;
        end else begin
          if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
          end
          if (imem_ack) begin
            state_d = FETCH;
          end
        end
      end

      ERR: begin
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Address register follows the fetch PC except while draining a stale request
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= IF_NOP;
      slot_pc_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      slot_pc_q <= slot_pc_d;
      terr_q    <= terr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: behavioural instruction memory with
// programmable latency, a scoreboard of expected PCs popped on each slot
// consumption, and cycle-exact checks of request/stall/redirect/timeout behaviour.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        timeout_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned lat      = 0;
  int unsigned age      = 0;
  logic [31:0] exp_q[$];

  if_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (16),
    .CNT_W    (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  // Instruction memory: acks once a request has been up for 'lat' extra cycles
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (age == lat) begin
          imem_ack   = 1'b1;
          imem_rdata = instr_of(imem_addr);
          age        = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hBAD0_BAD0;
          age        = age + 1;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        age        = 0;
      end
    end
  end

  // Scoreboard: every slot taken by ID must match the next expected fetch
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_slot", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, instr_of(e));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 32'(imem_req), 32'd0);

    // Zero-wait memory: one instruction per cycle from RESET_PC
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    cyc();
    @(negedge clk);
    chk("t1_req",  32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("t1_valid", 32'(if_valid), 32'd1);
      chk("t1_pc", if_pc, 32'(i * 4));
    end

    // Redirect coincident with stall on a valid slot (pc 16)
    cyc();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    chk("t5_slot_held", 32'(if_valid), 32'd1);
    chk("t5_slot_pc", if_pc, 32'h10);
    chk("t5_no_req", 32'(imem_req), 32'd0);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    cyc();
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    chk("t5_flushed", 32'(if_valid), 32'd0);
    chk("t5_nop", if_instr, 32'h0);
    chk("t5_target", imem_addr, 32'h40);

    // Three-wait memory: address held, one valid cycle per instruction
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("t2_addr_stable", imem_addr, 32'h40);
      chk("t2_req_held", 32'(imem_req), 32'd1);
      chk("t2_wait_empty", 32'(if_valid), 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("t2_valid", 32'(if_valid), 32'd1);
    chk("t2_pc", if_pc, 32'h40);
    chk("t2_next_addr", imem_addr, 32'h44);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("t2_one_per_instr", 32'(if_valid), 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("t2_valid2", 32'(if_valid), 32'd1);
    chk("t2_pc2", if_pc, 32'h44);
    chk("t2_launch_addr", imem_addr, 32'h48);

    // Redirect to an unaligned target while a request is pending
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    chk("t4_pending_req", 32'(imem_req), 32'd1);
    chk("t4_pending_addr", imem_addr, 32'h48);
    exp_q.push_back(32'h100);
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      chk("t4_drain_req", 32'(imem_req), 32'd1);
      chk("t4_drain_addr", imem_addr, 32'h48);
      chk("t4_drain_empty", 32'(if_valid), 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("t4_dropped", 32'(if_valid), 32'd0);
    chk("t4_new_addr", imem_addr, 32'h100);
    repeat (3) cyc();
    cyc();
    lat = 0;
    @(negedge clk);
    chk("t4_target_valid", 32'(if_valid), 32'd1);
    chk("t4_target_pc", if_pc, 32'h100);

    // Stall with pc 8 in the slot
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    @(negedge clk);
    chk("t3_pre_pc", if_pc, 32'h104);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    cyc();
    @(negedge clk);
    chk("t3_flush", 32'(if_valid), 32'd0);
    chk("t3_addr8", imem_addr, 32'h8);
    for (int i = 0; i < 4; i++) begin
      cyc();
      stall = 1'b1;
      @(negedge clk);
      chk("t3_hold_valid", 32'(if_valid), 32'd1);
      chk("t3_hold_pc", if_pc, 32'h8);
      chk("t3_no_req", 32'(imem_req), 32'd0);
    end
    cyc();
    stall = 1'b0;
    @(negedge clk);
    chk("t3_release_req", 32'(imem_req), 32'd1);
    chk("t3_release_addr", imem_addr, 32'hC);

    // Memory that never acknowledges
    cyc();
    lat = 255;
    @(negedge clk);
    chk("t3_pc12", if_pc, 32'hC);
    chk("t3_valid12", 32'(if_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      @(negedge clk);
      chk("t6_waiting_req", 32'(imem_req), 32'd1);
      chk("t6_no_err_yet", 32'(timeout_err), 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("t6_err", 32'(timeout_err), 32'd1);
    chk("t6_req_off", 32'(imem_req), 32'd0);
    chk("t6_valid_off", 32'(if_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t6_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset in the middle of ERR
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_terr",  32'(timeout_err), 32'd0);
    chk("t6_rst_req",   32'(imem_req), 32'd0);
    chk("t6_rst_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_instr", if_instr, 32'h0);
    chk("t6_rst_pc",    if_pc, 32'h0);
    chk("t6_rst_addr",  imem_addr, 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
